// File: rtl/cross_bar_arbiter_if.sv
// Request/grant bundle between a crossbar slave port's decoded requests and its arbiter.
// Latency: none, wires only.
// Backpressure: requests are levels held until slave_ack; grant is the only response.
interface cross_bar_arbiter_if #(
  parameter int MASTER_N = 4,
  parameter int IDX_W    = (MASTER_N > 1) ? $clog2(MASTER_N) : 1
);
  logic [MASTER_N-1:0] req;
  logic                slave_ack;
  logic [MASTER_N-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                timeout_err;

  // requesting side: crossbar decode logic and the slave's ack
  modport master (
    output req, slave_ack,
    input  grant, grant_idx, grant_valid, timeout_err
  );

  // arbiter side
  modport slave (
    input  req, slave_ack,
    output grant, grant_idx, grant_valid, timeout_err
  );
endinterface

// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter; one-hot grant held until slave ack, then rotates.
// Latency: req sampled at edge N is granted on edge N (visible cycle N+1); >=1 idle cycle between grants.
// Backpressure: grant held while slave stalls; optional CROSS_BAR_ARB_TIMEOUT_EN forces release after TIMEOUT_CYCLES.
module cross_bar_arbiter #(
  parameter int MASTER_N       = 4,
  parameter int IDX_W          = (MASTER_N > 1) ? $clog2(MASTER_N) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                aresetn,
  cross_bar_arbiter_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  if (MASTER_N < 1) begin : g_bad_master_n
    $error("cross_bar_arbiter: MASTER_N must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cross_bar_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [MASTER_N-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic                grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [MASTER_N-1:0] served_q, served_d;

  logic [MASTER_N-1:0] elig;
  logic [MASTER_N-1:0] elig_rot;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    ptr_inc;

  // Masters already served stay blocked until they drop req once.
  assign elig     = bus.req & ~served_q;
  // Rotate so bit 0 of elig_rot corresponds to the master at ptr.
  assign elig_rot = MASTER_N'({elig, elig} >> ptr_q);
  // Next pointer after a completed transfer: the master after the current one.
  assign ptr_inc  = (grant_idx_q == IDX_W'(MASTER_N - 1)) ? '0 : grant_idx_q + IDX_W'(1);

  // Circular first-set search starting at ptr.
  always_comb begin
    logic [IDX_W:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int i = 0; i < MASTER_N; i++) begin
      if (!pick_vld && elig_rot[i]) begin
        pick_vld = 1'b1;
        sum      = {1'b0, ptr_q} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(MASTER_N)) begin
          sum = sum - (IDX_W+1)'(MASTER_N);
        end
        pick_idx = sum[IDX_W-1:0];
      end
    end
  end

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_done;
  logic             timeout_err_q, timeout_err_d;

  assign cnt_nxt  = cnt_q + CNT_W'(1);
  assign cnt_done = (state_q == BUSY) && (cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

  // Count BUSY cycles; held at zero in IDLE so it starts fresh on every grant.
  always_comb begin
    cnt_d = (state_q == BUSY) ? cnt_nxt : '0;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state and grant decisions.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    served_d      = served_q & bus.req;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d       = MASTER_N'(1) << pick_idx;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (bus.slave_ack) begin
          // Completed transfer: rotate and block stale re-request (set beats clear).
          grant_d                = '0;
          grant_valid_d          = 1'b0;
          ptr_d                  = ptr_inc;
          served_d[grant_idx_q]  = 1'b1;
          state_d                = IDLE;
        end else if (!bus.req[grant_idx_q]) begin
          // Master abort: release without touching rotation or mask.
          grant_d       = '0;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        end else if (cnt_done) begin
          // Slave stalled too long: release as if acked and flag it.
          grant_d                = '0;
          grant_valid_d          = 1'b0;
          ptr_d                  = ptr_inc;
          served_d[grant_idx_q]  = 1'b1;
          timeout_err_d          = 1'b1;
          state_d                = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
      served_q      <= '0;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      served_q      <= served_d;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Grant is never multi-hot.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!aresetn)
    $onehot0(grant_q));

  // Grant never switches directly between two masters.
  a_grant_via_zero: assert property (@(posedge clk) disable iff (!aresetn)
    (grant_q != $past(grant_q)) |-> (($past(grant_q) == '0) || (grant_q == '0)));

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Directed bench for cross_bar_arbiter with MASTER_N=4, TIMEOUT_CYCLES=16.
// Inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_cross_bar_arbiter;

  logic clk = 1'b0;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;

  cross_bar_arbiter_if #(.MASTER_N(4)) bus ();

  cross_bar_arbiter #(
    .MASTER_N       (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    aresetn       = 1'b0;
    bus.req       = '0;
    bus.slave_ack = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    aresetn       = 1'b0;
    bus.req       = '0;
    bus.slave_ack = 1'b0;
    tick();
    tick();
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_idx", 32'(bus.grant_idx), 32'h0);
    chk("reset_valid", 32'(bus.grant_valid), 32'h0);
    chk("reset_terr", 32'(bus.timeout_err), 32'h0);
    aresetn = 1'b1;

    // single requester, then confirm ptr moved to 3
    bus.req = 4'b0100;
    tick();
    chk("t1_grant", 32'(bus.grant), 32'h4);
    chk("t1_idx", 32'(bus.grant_idx), 32'h2);
    chk("t1_valid", 32'(bus.grant_valid), 32'h1);
    tick();
    tick();
    bus.slave_ack = 1'b1;
    tick();
    bus.slave_ack = 1'b0;
    chk("t1_release", 32'(bus.grant), 32'h0);
    chk("t1_release_valid", 32'(bus.grant_valid), 32'h0);
    bus.req = 4'b1011;
    tick();
    chk("t1_ptr3_grant", 32'(bus.grant), 32'h8);
    chk("t1_ptr3_idx", 32'(bus.grant_idx), 32'h3);

    // all request, each drops req for one cycle after its ack
    reset_dut();
    bus.req = 4'b1111;
    tick();
    chk("t2_first", 32'(bus.grant_idx), 32'h0);
    chk("t2_first_grant", 32'(bus.grant), 32'h1);
    for (int e = 0; e < 4; e++) begin
      tick();
      bus.slave_ack = 1'b1;
      tick();
      bus.slave_ack = 1'b0;
      chk("t2_gap", 32'(bus.grant), 32'h0);
      bus.req = 4'b1111 & ~(4'b0001 << e);
      tick();
      exp_g = 4'b0001 << ((e + 1) % 4);
      chk("t2_rr_idx", 32'(bus.grant_idx), 32'((e + 1) % 4));
      chk("t2_rr_grant", 32'(bus.grant), 32'(exp_g));
      bus.req = 4'b1111;
    end

    // stale request after ack is not re-granted until it toggles
    reset_dut();
    bus.req = 4'b0010;
    tick();
    chk("t3_grant", 32'(bus.grant), 32'h2);
    tick();
    bus.slave_ack = 1'b1;
    tick();
    bus.slave_ack = 1'b0;
    chk("t3_release", 32'(bus.grant), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t3_stale_blocked", 32'(bus.grant), 32'h0);
    end
    bus.req = 4'b0000;
    tick();
    chk("t3_low", 32'(bus.grant), 32'h0);
    bus.req = 4'b0010;
    tick();
    chk("t3_regrant", 32'(bus.grant), 32'h2);

    // reset during BUSY
    reset_dut();
    bus.req = 4'b0010;
    tick();
    chk("t4_grant", 32'(bus.grant), 32'h2);
    aresetn = 1'b0;
    tick();
    chk("t4_rst_grant", 32'(bus.grant), 32'h0);
    chk("t4_rst_valid", 32'(bus.grant_valid), 32'h0);
    chk("t4_rst_idx", 32'(bus.grant_idx), 32'h0);
    aresetn = 1'b1;
    bus.req = 4'b1010;
    tick();
    chk("t4_after_grant", 32'(bus.grant), 32'h2);
    chk("t4_after_idx", 32'(bus.grant_idx), 32'h1);

    // master abort of master 3
    reset_dut();
    bus.req = 4'b1000;
    tick();
    chk("t5_grant3", 32'(bus.grant), 32'h8);
    bus.req = 4'b1001;
    tick();
    chk("t5_hold", 32'(bus.grant), 32'h8);
    bus.req = 4'b0001;
    tick();
    chk("t5_abort", 32'(bus.grant), 32'h0);
    chk("t5_abort_valid", 32'(bus.grant_valid), 32'h0);
    tick();
    chk("t5_next", 32'(bus.grant), 32'h1);

    // abort leaves ptr at 0
    reset_dut();
    bus.req = 4'b0010;
    tick();
    chk("t5b_grant1", 32'(bus.grant), 32'h2);
    bus.req = 4'b0100;
    tick();
    chk("t5b_abort", 32'(bus.grant), 32'h0);
    bus.req = 4'b0110;
    tick();
    chk("t5b_ptr_kept", 32'(bus.grant), 32'h2);

    // ack in IDLE is ignored
    reset_dut();
    bus.slave_ack = 1'b1;
    tick();
    bus.slave_ack = 1'b0;
    chk("t6_idle_ack", 32'(bus.grant), 32'h0);
    chk("t6_idle_ack_valid", 32'(bus.grant_valid), 32'h0);
    bus.req = 4'b0011;
    tick();
    chk("t6_ptr_kept", 32'(bus.grant), 32'h1);

    // stalled slave
    reset_dut();
    bus.req = 4'b1100;
    tick();
    chk("t7_grant2", 32'(bus.grant), 32'h4);
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("t7_hold", 32'(bus.grant), 32'h4);
      chk("t7_no_terr", 32'(bus.timeout_err), 32'h0);
    end
    tick();
    chk("t7_tmo_grant", 32'(bus.grant), 32'h0);
    chk("t7_tmo_terr", 32'(bus.timeout_err), 32'h1);
    tick();
    chk("t7_next_grant", 32'(bus.grant), 32'h8);
    chk("t7_terr_pulse", 32'(bus.timeout_err), 32'h0);
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("t7_hold", 32'(bus.grant), 32'h4);
      chk("t7_no_terr", 32'(bus.timeout_err), 32'h0);
    end
    bus.slave_ack = 1'b1;
    tick();
    bus.slave_ack = 1'b0;
    chk("t7_release", 32'(bus.grant), 32'h0);
    tick();
    chk("t7_next_grant", 32'(bus.grant), 32'h8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
